// File: rtl/alu_fib_seq_pkg.sv
// Shared encodings for the Fibonacci operand-feed stage and the ALU it drives.
package alu_fib_seq_pkg;

   localparam int unsigned DATA_W = 6;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned FLAG_W = 4;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b100;
   localparam logic [OP_W-1:0] OP_OR  = 3'b101;
   localparam logic [OP_W-1:0] OP_NOT = 3'b110;
   localparam logic [OP_W-1:0] OP_XOR = 3'b111;

   localparam int unsigned FLAG_CF = 3;
   localparam int unsigned FLAG_S  = 2;
   localparam int unsigned FLAG_V  = 1;
   localparam int unsigned FLAG_Z  = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_fib_seq_alu.sv
// Combinational ALU: s selects the op, y is the result, f holds {CF,S,V,Z}.
module alu_fib_seq_alu
   import alu_fib_seq_pkg::*;
#(
   parameter int unsigned N = 6,
   parameter int unsigned M = 3,
   parameter int unsigned K = 4
) (
   input  logic [M-1:0] s,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y,
   output logic [K-1:0] f
);

   logic [N:0] r;

   // Result carries one extra bit so add carry and subtract borrow land in r[N].
   always_comb begin
      r = '0;
      f = '0;
      case (s)
         OP_ADD:  r = {1'b0, a} + {1'b0, b};
         OP_SUB:  r = {1'b0, a} - {1'b0, b};
         OP_AND:  r = {1'b0, a & b};
         OP_OR:   r = {1'b0, a | b};
         OP_NOT:  r = {1'b0, ~a};
         OP_XOR:  r = {1'b0, a ^ b};
         default: r = '0;
      endcase
      y = r[N-1:0];
      f[FLAG_CF] = r[N];
      f[FLAG_S]  = y[N-1];
      f[FLAG_Z]  = (y == '0);
      case (s)
         OP_ADD:  f[FLAG_V] = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
         OP_SUB:  f[FLAG_V] = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
         default: f[FLAG_V] = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_fib_seq.sv
// Fibonacci stream generator: feeds ALU sums back as operands and emits terms
// over valid/ready, flagging unsigned wrap-around via the ALU carry.
module alu_fib_seq
   import alu_fib_seq_pkg::*;
#(
   parameter int unsigned N     = DATA_W,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     f0,
   input  logic [N-1:0]     f1,
   input  logic [CNT_W-1:0] len,
   output logic             out_valid,
   output logic [N-1:0]     out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   state_t             state;
   logic [N-1:0]       ra;
   logic [N-1:0]       rb;
   logic               ra_w;
   logic               rb_w;
   logic [CNT_W-1:0]   cnt;
   logic [N-1:0]       sum;
   logic [FLAG_W-1:0]  flags;
   logic               cf;
   logic               fire;
   logic               unused_flags;

   alu_fib_seq_alu #(
      .N (N),
      .M (OP_W),
      .K (FLAG_W)
   ) u_alu (
      .s (OP_ADD),
      .a (ra),
      .b (rb),
      .y (sum),
      .f (flags)
   );

   assign cf           = flags[FLAG_CF];
   assign unused_flags = ^{flags[FLAG_S], flags[FLAG_V], flags[FLAG_Z]};
   assign fire         = out_valid & out_ready;

   // out_data shadows ra so the emitted term is always the head operand.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
         ra        <= '0;
         rb        <= '0;
         ra_w      <= 1'b0;
         rb_w      <= 1'b0;
         cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               if (start) begin
                  ra       <= f0;
                  rb       <= f1;
                  ra_w     <= 1'b0;
                  rb_w     <= 1'b0;
                  cnt      <= len;
                  ovf      <= 1'b0;
                  out_data <= f0;
                  busy     <= 1'b1;
                  if (len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state     <= EMIT;
                     out_valid <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (fire) begin
                  ra       <= rb;
                  ra_w     <= rb_w;
                  rb       <= sum;
                  // A wrapped operand taints every later term.
                  rb_w     <= cf | ra_w | rb_w;
                  ovf      <= ovf | ra_w;
                  cnt      <= cnt - CNT_W'(1);
                  out_data <= rb;
                  if (cnt == CNT_W'(1)) begin
                     state     <= DONE;
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_fib_seq.sv
// Directed bench for alu_fib_seq: table of seeded sequences plus hand-written
// backpressure, mid-sequence start and reset cases.
module tb_alu_fib_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [5:0] f0;
   logic [5:0] f1;
   logic [3:0] len;
   logic       out_valid;
   logic [5:0] out_data;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic       ovf;

   int n_cmp;
   int n_err;

   typedef struct packed {
      logic [5:0]        f0;
      logic [5:0]        f1;
      logic [3:0]        len;
      logic              wraps;
      logic [3:0]        wrap_idx;
      logic [0:15][5:0]  terms;
   } vec_t;

   vec_t vecs [9];

   alu_fib_seq #(.N(6), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .f0        (f0),
      .f1        (f1),
      .len       (len),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] a, input logic [5:0] b, input logic [3:0] l,
                               input logic w, input logic [3:0] wi, input logic [95:0] t);
      vec_t v;
      v.f0 = a;
      v.f1 = b;
      v.len = l;
      v.wraps = w;
      v.wrap_idx = wi;
      v.terms = t;
      return v;
   endfunction

   // Full sequence with out_ready held high; ovf becomes visible one term after the wrapped one.
   task automatic run_vec(input int k);
      vec_t v;
      v = vecs[k];
      @(negedge clk);
      start = 1'b1; f0 = v.f0; f1 = v.f1; len = v.len; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < int'(v.len); i++) begin
         chk("term_valid", 8'(out_valid), 8'd1);
         chk("term_data", 8'(out_data), 8'(v.terms[i]));
         chk("term_ovf", 8'(ovf), 8'(v.wraps && (i > int'(v.wrap_idx))));
         chk("term_busy", 8'(busy), 8'd1);
         chk("term_done", 8'(done), 8'd0);
         @(negedge clk);
      end
      chk("end_done", 8'(done), 8'd1);
      chk("end_busy", 8'(busy), 8'd1);
      chk("end_valid", 8'(out_valid), 8'd0);
      chk("end_ovf", 8'(ovf), 8'(v.wraps));
      @(negedge clk);
      chk("idle_done", 8'(done), 8'd0);
      chk("idle_busy", 8'(busy), 8'd0);
      chk("idle_valid", 8'(out_valid), 8'd0);
      chk("idle_ovf", 8'(ovf), 8'(v.wraps));
   endtask

   initial begin
      logic [5:0] bp_data [7];
      logic       bp_rdy  [7];
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1; start = 1'b0; f0 = '0; f1 = '0; len = '0; out_ready = 1'b0;

      vecs[0] = mk(6'd1, 6'd1, 4'd8, 1'b0, 4'd0,
                   {6'd1, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 48'd0});
      vecs[1] = mk(6'd1, 6'd1, 4'd12, 1'b1, 4'd10,
                   {6'd1, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21,
                    6'd34, 6'd55, 6'd25, 6'd16, 24'd0});
      vecs[2] = mk(6'd0, 6'd0, 4'd3, 1'b0, 4'd0, {6'd0, 6'd0, 6'd0, 78'd0});
      vecs[3] = mk(6'd63, 6'd1, 4'd4, 1'b1, 4'd2, {6'd63, 6'd1, 6'd0, 6'd1, 72'd0});
      vecs[4] = mk(6'd40, 6'd40, 4'd1, 1'b0, 4'd0, {6'd40, 90'd0});
      vecs[5] = mk(6'd40, 6'd40, 4'd2, 1'b0, 4'd0, {6'd40, 6'd40, 84'd0});
      vecs[6] = mk(6'd40, 6'd40, 4'd3, 1'b1, 4'd2, {6'd40, 6'd40, 6'd16, 78'd0});
      vecs[7] = mk(6'd0, 6'd1, 4'd15, 1'b1, 4'd11,
                   {6'd0, 6'd1, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13,
                    6'd21, 6'd34, 6'd55, 6'd25, 6'd16, 6'd41, 6'd57, 6'd0});
      vecs[8] = mk(6'd5, 6'd9, 4'd0, 1'b0, 4'd0, 96'd0);

      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", 8'(out_valid), 8'd0);
      chk("rst_data", 8'(out_data), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(done), 8'd0);
      chk("rst_ovf", 8'(ovf), 8'd0);
      rst = 1'b0;

      for (int k = 0; k < 9; k++) run_vec(k);

      // ovf holds in IDLE after a wrapping run, and reset clears it.
      run_vec(1);
      repeat (3) @(negedge clk);
      chk("ovf_hold", 8'(ovf), 8'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("ovf_rst", 8'(ovf), 8'd0);

      // Backpressure: ready pattern 1,0,0,1,1,0,1 over the valid cycles.
      bp_data = '{6'd2, 6'd3, 6'd3, 6'd3, 6'd5, 6'd8, 6'd8};
      bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      @(negedge clk);
      start = 1'b1; f0 = 6'd2; f1 = 6'd3; len = 4'd4;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 7; c++) begin
         out_ready = bp_rdy[c];
         chk("bp_valid", 8'(out_valid), 8'd1);
         chk("bp_data", 8'(out_data), 8'(bp_data[c]));
         @(negedge clk);
      end
      chk("bp_done", 8'(done), 8'd1);
      chk("bp_end_valid", 8'(out_valid), 8'd0);
      out_ready = 1'b1;
      @(negedge clk);

      // start pulsed mid-sequence must be ignored.
      @(negedge clk);
      start = 1'b1; f0 = 6'd1; f1 = 6'd1; len = 4'd8;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("ms_valid", 8'(out_valid), 8'd1);
         chk("ms_data", 8'(out_data), 8'(vecs[0].terms[i]));
         if (i == 3) begin
            start = 1'b1; f0 = 6'd7; f1 = 6'd7; len = 4'd2;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("ms_done", 8'(done), 8'd1);
      @(negedge clk);
      chk("ms_idle_busy", 8'(busy), 8'd0);
      chk("ms_idle_valid", 8'(out_valid), 8'd0);

      // Reset after the third accepted term, then a clean restart.
      @(negedge clk);
      start = 1'b1; f0 = 6'd1; f1 = 6'd1; len = 4'd8;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rm_data", 8'(out_data), 8'(vecs[0].terms[i]));
         @(negedge clk);
      end
      chk("rm_data3", 8'(out_data), 8'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rm_valid", 8'(out_valid), 8'd0);
      chk("rm_busy", 8'(busy), 8'd0);
      chk("rm_done", 8'(done), 8'd0);
      chk("rm_ovf", 8'(ovf), 8'd0);
      chk("rm_data", 8'(out_data), 8'd0);
      @(negedge clk);
      chk("rm_idle_valid", 8'(out_valid), 8'd0);
      run_vec(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
